// File: rtl/overlay_pkg.sv
// overlay_pkg: shared encodings and constants for the text overlay compositor.
package overlay_pkg;
   typedef enum logic [1:0] {MODE_OFF = 2'b00, MODE_STATIC = 2'b01, MODE_BLINK = 2'b10, MODE_SCROLL = 2'b11} mode_e;
   typedef enum logic {SHOW = 1'b0, HIDE = 1'b1} blink_e;
   localparam logic [9:0] H_ACTIVE = 10'd640;
   localparam logic [9:0] V_ACTIVE = 10'd480;
   localparam logic [5:0] SHADOW_RGB_DEF = 6'b01_01_01;
endpackage

// File: rtl/overlay_compositor_if.sv
// overlay_compositor_if: pixel position, layer controls, glyph lookups and composited output.
interface overlay_compositor_if #(parameter int NUM_LAYERS = 3) ();
   logic [9:0] x;
   logic [9:0] y;
   logic frame_active;
   logic [2*NUM_LAYERS-1:0] layer_mode;
   logic [6*NUM_LAYERS-1:0] layer_color;
   logic scroll_pause;
   logic [10*NUM_LAYERS-1:0] main_x;
   logic [10*NUM_LAYERS-1:0] main_y;
   logic [10*NUM_LAYERS-1:0] shad_x;
   logic [10*NUM_LAYERS-1:0] shad_y;
   logic [NUM_LAYERS-1:0] main_hit;
   logic [NUM_LAYERS-1:0] shad_hit;
   logic [5:0] overlay_rgb;
   logic overlay_active;
   logic frame_tick;
   modport slave (
      input x, y, frame_active, layer_mode, layer_color, scroll_pause, main_hit, shad_hit,
      output main_x, main_y, shad_x, shad_y, overlay_rgb, overlay_active, frame_tick
   );
   modport master (
      output x, y, frame_active, layer_mode, layer_color, scroll_pause, main_hit, shad_hit,
      input main_x, main_y, shad_x, shad_y, overlay_rgb, overlay_active, frame_tick
   );
endinterface

// File: rtl/overlay_anim_timer.sv
// overlay_anim_timer: frame-end detection, horizontal scroll offset and blink phase.
module overlay_anim_timer
   import overlay_pkg::*;
#(
   parameter int BLINK_FRAMES = 30,
   parameter int SCROLL_STEP = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic [9:0] y,
   input  logic scroll_pause,
   output logic frame_tick,
   output logic [9:0] scroll_x,
   output logic hide
);
   blink_e state, state_n;
   logic [7:0] cnt;
   logic armed;
   logic wrap;
   logic [10:0] sum;
   // armed means the previous cycle was off line 480, so a reset parked on 480 cannot tick
   assign frame_tick = armed && y == V_ACTIVE;
   assign wrap = frame_tick && cnt == 8'(BLINK_FRAMES - 1);
   assign sum = {1'b0, scroll_x} + 11'(SCROLL_STEP);
   assign hide = state == HIDE;
   always_comb begin
      state_n = state;
      if (wrap) state_n = state == SHOW ? HIDE : SHOW;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= SHOW;
      else state <= state_n;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         armed <= 1'b0;
         scroll_x <= '0;
      end else begin
         armed <= y != V_ACTIVE;
         if (frame_tick) cnt <= wrap ? 8'd0 : cnt + 8'd1;
         if (frame_tick && !scroll_pause)
            scroll_x <= sum >= {1'b0, H_ACTIVE} ? 10'(sum - {1'b0, H_ACTIVE}) : sum[9:0];
      end
endmodule

// File: rtl/overlay_compositor.sv
// overlay_compositor: priority compositing of up to four text layers with drop shadows,
// blink and horizontal scroll, producing a registered overlay colour per pixel.
module overlay_compositor
   import overlay_pkg::*;
#(
   parameter int NUM_LAYERS = 3,
   parameter int SHADOW_DX = 4,
   parameter int SHADOW_DY = 4,
   parameter int BLINK_FRAMES = 30,
   parameter int SCROLL_STEP = 2,
   parameter logic [5:0] SHADOW_RGB = SHADOW_RGB_DEF
) (
   input logic clk,
   input logic rst,
   overlay_compositor_if.slave bus
);
   logic [9:0] scroll_x;
   logic hide;
   logic [10:0] wsum;
   logic [9:0] sx;
   logic [NUM_LAYERS-1:0] vis;
   logic [5:0] rgb;
   logic act;
   overlay_anim_timer #(.BLINK_FRAMES(BLINK_FRAMES), .SCROLL_STEP(SCROLL_STEP)) u_timer (
      .clk(clk), .rst(rst), .y(bus.y), .scroll_pause(bus.scroll_pause),
      .frame_tick(bus.frame_tick), .scroll_x(scroll_x), .hide(hide)
   );
   assign wsum = {1'b0, bus.x} + {1'b0, scroll_x};
   assign sx = bus.x < H_ACTIVE ? (wsum >= {1'b0, H_ACTIVE} ? 10'(wsum - {1'b0, H_ACTIVE}) : wsum[9:0]) : bus.x;
   for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
      mode_e mode;
      logic [9:0] mx;
      assign mode = mode_e'(bus.layer_mode[2*i +: 2]);
      assign mx = mode == MODE_SCROLL ? sx : bus.x;
      assign bus.main_x[10*i +: 10] = mx;
      assign bus.main_y[10*i +: 10] = bus.y;
      assign bus.shad_x[10*i +: 10] = mx - 10'(SHADOW_DX);
      assign bus.shad_y[10*i +: 10] = bus.y - 10'(SHADOW_DY);
      assign vis[i] = mode != MODE_OFF && !(mode == MODE_BLINK && hide);
   end
   // scan from lowest priority upward so layer 0 overwrites last; a layer's shadow blocks lower layers
   always_comb begin
      rgb = '0;
      act = 1'b0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--)
         if (vis[i] && (bus.main_hit[i] || bus.shad_hit[i])) begin
            rgb = bus.main_hit[i] ? bus.layer_color[6*i +: 6] : SHADOW_RGB;
            act = 1'b1;
         end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.overlay_rgb <= '0;
         bus.overlay_active <= 1'b0;
      end else begin
         bus.overlay_rgb <= bus.frame_active ? rgb : 6'd0;
         bus.overlay_active <= bus.frame_active && act;
      end
endmodule

// File: doc/overlay_compositor.md
OVERLAY_COMPOSITOR -- requirements
Module: overlay_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 3, the number of text layers (1..4); index 0 has the highest priority.
REQ-002 SHALL have parameter SHADOW_DX, default 4, the shadow x offset in pixels.
REQ-003 SHALL have parameter SHADOW_DY, default 4, the shadow y offset in pixels.
REQ-004 SHALL have parameter BLINK_FRAMES, default 30, the frames per blink half-period (1..255).
REQ-005 SHALL have parameter SCROLL_STEP, default 2, the pixels added to the scroll offset per frame (0..639).
REQ-006 SHALL have parameter SHADOW_RGB, default 6'b01_01_01, the shadow colour.
REQ-007 SHALL have port clk, input, 1 bit, the pixel clock; the block's only clock.
REQ-008 SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-009 SHALL have port x, y, input, 10 bits each, the current pixel coordinates.
REQ-010 SHALL have port frame_active, input, 1 bit, high inside the 640x480 visible area.
REQ-011 SHALL have port layer_mode, input, 2*NUM_LAYERS bits, per-layer mode: 00 off, 01 static, 10 blink, 11 scroll.
REQ-012 SHALL have port layer_color, input, 6*NUM_LAYERS bits, per-layer main colour (RRGGBB).
REQ-013 SHALL have port scroll_pause, input, 1 bit, which freezes the scroll offset while high.
REQ-014 SHALL have ports main_x, main_y, output, 10*NUM_LAYERS bits each, per-layer glyph lookup coordinates for the main text.
REQ-015 SHALL have ports shad_x, shad_y, output, 10*NUM_LAYERS bits each, per-layer glyph lookup coordinates for the shadow.
REQ-016 SHALL have ports main_hit, shad_hit, input, NUM_LAYERS bits each, returned combinationally by external glyph generators.
REQ-017 SHALL have port overlay_rgb, output, 6 bits, the registered composited colour.
REQ-018 SHALL have port overlay_active, output, 1 bit, registered; high when any visible layer hit occurs.
REQ-019 SHALL have port frame_tick, output, 1 bit, a one-cycle pulse at frame end.

Function
REQ-020 SHALL assert frame_tick for exactly one cycle on the first cycle where y==480 after a cycle where y!=480.
REQ-021 SHALL keep a 10-bit scroll_x register: on frame_tick with scroll_pause low, scroll_x becomes scroll_x+SCROLL_STEP, minus 640 if the result is 640 or more; with scroll_pause high it holds.
REQ-022 SHALL implement a blink FSM with states SHOW and HIDE and an 8-bit frame counter; on frame_tick the counter increments; on reaching BLINK_FRAMES-1 it clears and the state toggles; blink and counter advance regardless of scroll_pause.
REQ-023 SHALL drive main_x[i] = (x+scroll_x) mod 640 for scroll-mode layers when x<640, and main_x[i] = x otherwise; main_y[i] = y.
REQ-024 SHALL drive shad_x[i] = main_x[i]-SHADOW_DX and shad_y[i] = main_y[i]-SHADOW_DY, both modulo 1024.
REQ-025 SHALL treat a layer as visible when its mode is not 00 and not (mode 10 and FSM in HIDE); mode changes SHALL take effect combinationally on the current pixel.
REQ-026 SHALL composite by taking the lowest-index visible layer with main_hit or shad_hit; within that layer, main_hit yields layer_color[i], otherwise SHADOW_RGB; if no visible layer hits, the colour is 0.
REQ-027 SHALL register overlay_rgb and overlay_active with 1-cycle latency from x/y; both SHALL be 0 when frame_active was low in the sampled cycle.
REQ-028 SHALL not let a higher-index layer's main hit override a lower-index layer's shadow hit.

Reset
REQ-029 SHALL, while rst is high, immediately force overlay_rgb=0, overlay_active=0, frame_tick=0, scroll_x=0, blink counter=0, FSM=SHOW and the y==480 history flag=0, including mid-frame.
REQ-030 SHALL produce the first frame_tick after reset release only on a fresh transition of y to 480.

Structure
REQ-031 SHALL place the mode encodings, H_ACTIVE=640, V_ACTIVE=480 and the default SHADOW_RGB in the shared package overlay_pkg.
REQ-032 SHALL place frame-tick detection, scroll_x and the blink FSM in one sub-module, overlay_anim_timer.

Verification
REQ-033 SHALL verify: layer0 static with colour 110000 and main_hit, layer1 shadow hit at the same pixel -> overlay_rgb=110000 one cycle later.
REQ-034 SHALL verify: layer0 with only shad_hit -> overlay_rgb=010101 and overlay_active=1; with frame_active=0 -> both 0.
REQ-035 SHALL verify: SCROLL_STEP=2 run for 321 frame ticks -> scroll_x sequence 2,4,...,638,0,2; main_x for x=639 at scroll_x=2 is 1.
REQ-036 SHALL verify: BLINK_FRAMES=30 with a mode-10 layer hit -> visible for frames 0-29, black for 30-59, visible again at frame 60.
REQ-037 SHALL verify: scroll_pause held high across 5 ticks -> scroll_x unchanged while blink counter advances by 5.
REQ-038 SHALL verify: rst asserted mid-line with scroll_x=100 -> outputs 0 that cycle, scroll_x=0, FSM=SHOW, and no frame_tick while y stays at 480 after release.
